// File: rtl/tcdm_bank_mux.sv
// Purpose: round-robin merge of NumInp request ports onto one TCDM adapter port, routing in-order responses back.
// Latency: zero cycles on both request and response paths (combinational mux); state updates on clk_i.
// Backpressure: out_ready_i propagates to the granted port only; loads stall while the response-index FIFO is full.

// Purpose: small generic FIFO holding one entry per outstanding request.
// Latency: one cycle from push to visibility at the head (no bypass).
// Backpressure: push is ignored when full and pop when empty; the caller gates on full/empty.
module tcdm_bank_mux_fifo #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_vld,
    input  logic [Width-1:0] push_dat,
    input  logic             pop_vld,
    output logic [Width-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == CntW'(Depth));
    assign empty   = (cnt_q == '0);
    // A full FIFO refuses a push even when the same cycle pops.
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_vld && !empty;
    assign pop_dat = mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap at Depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_dat;
        end
    end
endmodule

module tcdm_bank_mux #(
    parameter int unsigned NumInp    = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter type         metadata_t = logic,
    parameter int unsigned RespDepth = 4,
    localparam int unsigned BeWidth  = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumInp-1:0]    req_valid_i,
    output logic [NumInp-1:0]    req_ready_o,
    input  logic [AddrWidth-1:0] req_address_i [NumInp],
    input  logic [3:0]           req_amo_i     [NumInp],
    input  logic [NumInp-1:0]    req_write_i,
    input  logic [DataWidth-1:0] req_wdata_i   [NumInp],
    input  metadata_t            req_meta_i    [NumInp],
    input  logic [BeWidth-1:0]   req_be_i      [NumInp],
    output logic [NumInp-1:0]    resp_valid_o,
    input  logic [NumInp-1:0]    resp_ready_i,
    output logic [DataWidth-1:0] resp_rdata_o  [NumInp],
    output metadata_t            resp_meta_o   [NumInp],
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [AddrWidth-1:0] out_address_o,
    output logic [3:0]           out_amo_o,
    output logic                 out_write_o,
    output logic [DataWidth-1:0] out_wdata_o,
    output metadata_t            out_meta_o,
    output logic [BeWidth-1:0]   out_be_o,
    input  logic                 out_valid_i,
    output logic                 out_ready_o,
    input  logic [DataWidth-1:0] out_rdata_i,
    input  metadata_t            out_meta_i
);
    localparam int unsigned IdxW = $clog2(NumInp);

    logic [IdxW-1:0] rr_q, lock_idx_q, win_idx, head_idx;
    logic            lock_q, win_found, fifo_full, fifo_empty;
    logic            req_hs, push, pop;

    // Pick the winner: a held lock wins outright, otherwise search from rr_q skipping loads while the FIFO is full.
    always_comb begin
        logic [IdxW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (lock_q) begin
            win_found = req_valid_i[lock_idx_q];
            win_idx   = lock_idx_q;
        end else begin
            for (int unsigned i = 0; i < NumInp; i++) begin
                cand = IdxW'((32'(rr_q) + i) % NumInp);
                if (!win_found && req_valid_i[cand] && (req_write_i[cand] || !fifo_full)) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    assign out_valid_o   = win_found;
    assign out_address_o = req_address_i[win_idx];
    assign out_amo_o     = req_amo_i[win_idx];
    assign out_write_o   = req_write_i[win_idx];
    assign out_wdata_o   = req_wdata_i[win_idx];
    assign out_meta_o    = req_meta_i[win_idx];
    assign out_be_o      = req_be_i[win_idx];

    assign req_hs = win_found && out_ready_i;
    assign push   = req_hs && !req_write_i[win_idx];
    assign pop    = !fifo_empty && out_valid_i && resp_ready_i[head_idx];

    // Only the granted port sees the adapter's ready.
    always_comb begin
        req_ready_o = '0;
        if (win_found) begin
            req_ready_o[win_idx] = out_ready_i;
        end
    end

    // Advance the round-robin pointer past the winner and hold the grant across a stalled output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            if (req_hs) begin
                rr_q <= IdxW'((32'(win_idx) + 1) % NumInp);
            end
            lock_q <= win_found && !out_ready_i;
            if (win_found && !out_ready_i) begin
                lock_idx_q <= win_idx;
            end
        end
    end

    tcdm_bank_mux_fifo #(
        .Width (IdxW),
        .Depth (RespDepth)
    ) i_idx_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (push),
        .push_dat (win_idx),
        .pop_vld  (pop),
        .pop_dat  (head_idx),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Steer the adapter response to the port at the FIFO head; data is broadcast to every port.
    always_comb begin
        resp_valid_o = '0;
        out_ready_o  = 1'b0;
        if (!fifo_empty) begin
            resp_valid_o[head_idx] = out_valid_i;
            out_ready_o            = resp_ready_i[head_idx];
        end
        for (int unsigned p = 0; p < NumInp; p++) begin
            resp_rdata_o[p] = out_rdata_i;
            resp_meta_o[p]  = out_meta_i;
        end
    end

    // A response with nothing outstanding means the adapter and this mux disagree on ordering.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(out_valid_i && fifo_empty))
        else $error("tcdm_bank_mux: response received with no outstanding request");
endmodule

// File: tb/tb_tcdm_bank_mux.sv
module tb_tcdm_bank_mux;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [3:0]  req_valid_i, req_ready_o, req_write_i, resp_valid_o, resp_ready_i;
    logic [31:0] req_address_i [4];
    logic [3:0]  req_amo_i     [4];
    logic [31:0] req_wdata_i   [4];
    logic        req_meta_i    [4];
    logic [3:0]  req_be_i      [4];
    logic [31:0] resp_rdata_o  [4];
    logic        resp_meta_o   [4];
    logic        out_valid_o, out_ready_i, out_write_o, out_meta_o;
    logic [31:0] out_address_o, out_wdata_o;
    logic [3:0]  out_amo_o, out_be_o;
    logic        out_valid_i, out_ready_o, out_meta_i;
    logic [31:0] out_rdata_i;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk_i = ~clk_i;

    tcdm_bank_mux dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_address_i (req_address_i),
        .req_amo_i     (req_amo_i),
        .req_write_i   (req_write_i),
        .req_wdata_i   (req_wdata_i),
        .req_meta_i    (req_meta_i),
        .req_be_i      (req_be_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_rdata_o  (resp_rdata_o),
        .resp_meta_o   (resp_meta_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_address_o (out_address_o),
        .out_amo_o     (out_amo_o),
        .out_write_o   (out_write_o),
        .out_wdata_o   (out_wdata_o),
        .out_meta_o    (out_meta_o),
        .out_be_o      (out_be_o),
        .out_valid_i   (out_valid_i),
        .out_ready_o   (out_ready_o),
        .out_rdata_i   (out_rdata_i),
        .out_meta_i    (out_meta_i)
    );

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  wr;
        logic        ordy;
        logic        ovld;
        logic [3:0]  rrdy;
        logic [31:0] rdata;
        logic        e_ovld;
        int          e_port;
        logic [3:0]  e_req_rdy;
        logic        e_out_rdy;
        logic [3:0]  e_resp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] vld, input logic [3:0] wr, input logic ordy, input logic ovld,
                       input logic [3:0] rrdy, input logic [31:0] rdata, input logic e_ovld, input int e_port,
                       input logic [3:0] e_req_rdy, input logic e_out_rdy, input logic [3:0] e_resp);
        vec_t v;
        v.vld = vld; v.wr = wr; v.ordy = ordy; v.ovld = ovld; v.rrdy = rrdy; v.rdata = rdata;
        v.e_ovld = e_ovld; v.e_port = e_port; v.e_req_rdy = e_req_rdy;
        v.e_out_rdy = e_out_rdy; v.e_resp = e_resp;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] vld, input logic [3:0] wr, input logic ordy, input logic ovld,
                         input logic [3:0] rrdy, input logic [31:0] rdata);
        req_valid_i  = vld;
        req_write_i  = wr;
        out_ready_i  = ordy;
        out_valid_i  = ovld;
        resp_ready_i = rrdy;
        out_rdata_i  = rdata;
        out_meta_i   = rdata[0];
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " out_valid"},  32'(out_valid_o),  32'd0);
        chk({tag, " out_ready"},  32'(out_ready_o),  32'd0);
        chk({tag, " resp_valid"}, 32'(resp_valid_o), 32'd0);
        chk({tag, " req_ready"},  32'(req_ready_o),  32'd0);
    endtask

    initial begin
        for (int p = 0; p < 4; p++) begin
            req_address_i[p] = 32'h1000 + 32'(16 * p);
            req_amo_i[p]     = 4'(p);
            req_wdata_i[p]   = 32'hD000 + 32'(p);
            req_meta_i[p]    = 1'(p & 1);
            req_be_i[p]      = 4'hF;
        end

        // vld  wr   ordy ovld rrdy  rdata   e_ovld port req_rdy out_rdy resp
        // Four loads, rotating grants; FIFO fills with 0,1,2,3.
        add(4'hF, 4'h0, 1, 0, 4'h0, 32'h0,  1, 0, 4'b0001, 0, 4'b0000);
        add(4'hF, 4'h0, 1, 0, 4'h0, 32'h0,  1, 1, 4'b0010, 0, 4'b0000);
        add(4'hF, 4'h0, 1, 0, 4'h0, 32'h0,  1, 2, 4'b0100, 0, 4'b0000);
        add(4'hF, 4'h0, 1, 0, 4'h0, 32'h0,  1, 3, 4'b1000, 0, 4'b0000);
        // Full FIFO popping this cycle still blocks the loads; granted next cycle.
        add(4'hF, 4'h0, 1, 1, 4'hF, 32'hA0, 0, 0, 4'b0000, 1, 4'b0001);
        add(4'hF, 4'h0, 1, 1, 4'hF, 32'hA1, 1, 0, 4'b0001, 1, 4'b0010);
        add(4'h0, 4'h0, 1, 1, 4'hF, 32'hA2, 0, 0, 4'b0000, 1, 4'b0100);
        add(4'h0, 4'h0, 1, 1, 4'hF, 32'hA3, 0, 0, 4'b0000, 1, 4'b1000);
        add(4'h0, 4'h0, 1, 1, 4'hF, 32'hA4, 0, 0, 4'b0000, 1, 4'b0001);
        add(4'h0, 4'h0, 1, 0, 4'hF, 32'h0,  0, 0, 4'b0000, 0, 4'b0000);
        // Port 2 store stalled 3 cycles while port 1 raises valid; then 3, 0, 1.
        add(4'b0100, 4'b0100, 0, 0, 4'hF, 32'h0, 1, 2, 4'b0000, 0, 4'b0000);
        add(4'b0110, 4'b1101, 0, 0, 4'hF, 32'h0, 1, 2, 4'b0000, 0, 4'b0000);
        add(4'b0110, 4'b1101, 0, 0, 4'hF, 32'h0, 1, 2, 4'b0000, 0, 4'b0000);
        add(4'b0110, 4'b1101, 1, 0, 4'hF, 32'h0, 1, 2, 4'b0100, 0, 4'b0000);
        add(4'b1011, 4'b1101, 1, 0, 4'hF, 32'h0, 1, 3, 4'b1000, 0, 4'b0000);
        add(4'b0011, 4'b1101, 1, 0, 4'hF, 32'h0, 1, 0, 4'b0001, 0, 4'b0000);
        add(4'b0010, 4'b1101, 1, 0, 4'hF, 32'h0, 1, 1, 4'b0010, 0, 4'b0000);
        add(4'b0000, 4'b0000, 1, 1, 4'hF, 32'hA5, 0, 0, 4'b0000, 1, 4'b0010);
        // Four loads from port 0 fill the FIFO; a load is blocked but a store passes.
        add(4'b0001, 4'b0000, 1, 0, 4'hF, 32'h0, 1, 0, 4'b0001, 0, 4'b0000);
        add(4'b0001, 4'b0000, 1, 0, 4'hF, 32'h0, 1, 0, 4'b0001, 1, 4'b0000);
        add(4'b0001, 4'b0000, 1, 0, 4'hF, 32'h0, 1, 0, 4'b0001, 1, 4'b0000);
        add(4'b0001, 4'b0000, 1, 0, 4'hF, 32'h0, 1, 0, 4'b0001, 1, 4'b0000);
        add(4'b0011, 4'b0010, 1, 0, 4'hF, 32'h0, 1, 1, 4'b0010, 1, 4'b0000);
        add(4'b0000, 4'b0000, 1, 1, 4'hF, 32'hA6, 0, 0, 4'b0000, 1, 4'b0001);
        add(4'b0000, 4'b0000, 1, 1, 4'hF, 32'hA7, 0, 0, 4'b0000, 1, 4'b0001);
        add(4'b0000, 4'b0000, 1, 1, 4'hF, 32'hA8, 0, 0, 4'b0000, 1, 4'b0001);
        add(4'b0000, 4'b0000, 1, 1, 4'hF, 32'hA9, 0, 0, 4'b0000, 1, 4'b0001);
        // Head = port 3 with its ready low: response stalls regardless of other readies.
        add(4'b1000, 4'b0000, 1, 0, 4'hF,    32'h0,  1, 3, 4'b1000, 0, 4'b0000);
        add(4'b0010, 4'b0000, 1, 1, 4'b0111, 32'hB0, 1, 1, 4'b0010, 0, 4'b1000);
        add(4'b0000, 4'b0000, 1, 1, 4'b0111, 32'hB0, 0, 0, 4'b0000, 0, 4'b1000);
        add(4'b0000, 4'b0000, 1, 1, 4'b1000, 32'hB0, 0, 0, 4'b0000, 1, 4'b1000);
        // Leave two entries outstanding (ports 1 and 0) ahead of the reset sequence.
        add(4'b0001, 4'b0000, 1, 0, 4'hF,    32'h0,  1, 0, 4'b0001, 1, 4'b0000);

        // Reset state with idle inputs.
        rst_ni = 1'b0;
        drive(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        #3;
        chk_idle_outputs("reset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            @(negedge clk_i);
            drive(v.vld, v.wr, v.ordy, v.ovld, v.rrdy, v.rdata);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid_o), 32'(v.e_ovld));
            if (v.e_ovld) begin
                chk($sformatf("v%0d out_address", i), out_address_o, 32'h1000 + 32'(16 * v.e_port));
                chk($sformatf("v%0d out_write", i), 32'(out_write_o), 32'(v.wr[v.e_port]));
                chk($sformatf("v%0d out_meta", i), 32'(out_meta_o), 32'(v.e_port & 1));
            end
            chk($sformatf("v%0d req_ready", i), 32'(req_ready_o), 32'(v.e_req_rdy));
            chk($sformatf("v%0d out_ready", i), 32'(out_ready_o), 32'(v.e_out_rdy));
            chk($sformatf("v%0d resp_valid", i), 32'(resp_valid_o), 32'(v.e_resp));
            if (v.ovld) begin
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("v%0d resp_rdata[%0d]", i, k), resp_rdata_o[k], v.rdata);
                    chk($sformatf("v%0d resp_meta[%0d]", i, k), 32'(resp_meta_o[k]), 32'(v.rdata[0]));
                end
            end
        end

        // Reset mid-operation with two outstanding entries; outputs clear asynchronously.
        @(negedge clk_i);
        drive(4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0);
        #1;
        chk("pre-reset out_ready", 32'(out_ready_o), 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk_idle_outputs("async reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        // Pointer back at 0: with all ports loading, port 0 wins; FIFO is empty.
        @(negedge clk_i);
        drive(4'hF, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0);
        #1;
        chk("post-reset out_address", out_address_o, 32'h1000);
        chk("post-reset req_ready", 32'(req_ready_o), 32'b0001);
        chk("post-reset out_ready", 32'(out_ready_o), 32'd0);
        @(negedge clk_i);
        drive(4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0);
        #1;
        chk("post-reset first push out_ready", 32'(out_ready_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/tcdm_bank_mux.md
# tcdm_bank_mux

Round-robin request multiplexer in front of `tcdm_adapter` in each TCDM bank. It merges `NumInp` valid/ready request ports (local tile cores plus remote-group ports) onto the adapter's single request port. It records which port issued each response-bearing request and routes the adapter's in-order responses back to that port.

## Interface
Parameters:
- `NumInp`, 4: number of request ports, ≥ 2.
- `AddrWidth`, 32: address width.
- `DataWidth`, 32: data width. `BeWidth = DataWidth/8` is derived.
- `metadata_t`, logic: request metadata type, passed through unchanged.
- `RespDepth`, 4: depth of the outstanding-response index FIFO, ≥ 2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_i` in 1: clock.
  - `rst_ni` in 1: asynchronous, active-low reset.
- Request side, one entry per input port:
  - `req_valid_i` in [NumInp]: request valid.
  - `req_ready_o` out [NumInp]: request ready.
  - `req_address_i` in [NumInp][AddrWidth]: address.
  - `req_amo_i` in [NumInp][4]: AMO opcode.
  - `req_write_i` in [NumInp]: 1 = store.
  - `req_wdata_i` in [NumInp][DataWidth]: write data.
  - `req_meta_i` in [NumInp] metadata_t: request metadata.
  - `req_be_i` in [NumInp][BeWidth]: byte enable.
- Response side, one entry per input port:
  - `resp_valid_o` out [NumInp]: response valid.
  - `resp_ready_i` in [NumInp]: response ready.
  - `resp_rdata_o` out [NumInp][DataWidth]: read data.
  - `resp_meta_o` out [NumInp] metadata_t: response metadata.
- Request output, toward the adapter:
  - `out_valid_o` out 1, `out_ready_i` in 1: request handshake.
  - `out_address_o` out AddrWidth, `out_amo_o` out 4, `out_write_o` out 1.
  - `out_wdata_o` out DataWidth, `out_meta_o` out metadata_t, `out_be_o` out BeWidth.
- Response input, from the adapter:
  - `out_valid_i` in 1, `out_ready_o` out 1: response handshake.
  - `out_rdata_i` in DataWidth, `out_meta_i` in metadata_t: response data and metadata.

## Operation
- **Response-bearing request:** any request with `write == 0`, including loads, AMOs, LR, SC and LR wake-up requests. Exactly one response returns per such request, in issue order. Stores produce no response.
- **Arbitration:**
  - Round-robin pointer `rr_q`, reset 0.
  - The winner is the first port with `req_valid_i` set, searching `rr_q`, `rr_q+1`, … modulo NumInp.
  - On a request handshake with winner w, `rr_q <= (w+1) mod NumInp`.
  - No handshake → `rr_q` holds.
- **Lock:** while `out_valid_o && !out_ready_i`, the granted port is registered (`lock_q`, `lock_idx_q`) and held; the output payload must stay stable. The lock clears on the handshake. Upstream ports must keep valid and payload stable until ready.
- **Eligibility:** a port may be granted only if its request is a store or the index FIFO is not full. A port blocked by a full FIFO is skipped by the search. It is never granted while blocked.
- **Request path:**
  - `out_valid_o` = a winner exists.
  - Payload = the winner's fields.
  - `req_ready_o[w] = out_ready_i`; all other ports' ready = 0.
- **Index FIFO:**
  - Width `$clog2(NumInp)`, depth RespDepth.
  - Push the winner index on a handshake with `write == 0`.
  - Pop on a response handshake.
  - Full blocks a push even in a cycle that also pops.
  - Empty with a simultaneous push: the push is stored. It is not bypassed to the response path in the same cycle.
  - Read/write pointers wrap modulo RespDepth; the occupancy counter spans 0..RespDepth.
- **Response routing:**
  - If the FIFO is non-empty with head h: `resp_valid_o[h] = out_valid_i`, `out_ready_o = resp_ready_i[h]`.
  - All ports' `resp_rdata_o` and `resp_meta_o` show `out_rdata_i` and `out_meta_i`.
  - FIFO empty: `out_ready_o = 0` and all `resp_valid_o = 0`. `out_valid_i` asserted while the FIFO is empty is a protocol error; a simulation assertion flags it.
- **Reset mid-operation:** FIFO, lock and pointer clear immediately. Outstanding responses are discarded.

## Timing
- Request and response paths are combinational: zero-cycle mux, no added latency.
- State updates on the rising edge of `clk_i`.
- The FIFO, `rr_q` and lock are the only sequential state. The request-to-response path has no combinational loop: `out_ready_o` depends only on FIFO state and `resp_ready_i`.
- Reset values with all inputs idle: `out_valid_o = 0`, `out_ready_o = 0`, all `resp_valid_o = 0`, all `req_ready_o = 0`.
- Throughput: one request per cycle and one response per cycle, concurrently.

## Test plan
- All four ports assert a load each cycle, `out_ready_i = 1` → grants cycle 0,1,2,3,0,…; FIFO contents = 0,1,2,3. Then responses rdata 0xA0..0xA3 → `resp_valid_o[0..3]` asserted in that order with matching data.
- Port 2 stores to 0x40 with `out_ready_i = 0` for 3 cycles, port 1 raising valid meanwhile → payload stays port 2 for 3 cycles; grant moves to port 3 next, then port 0, then port 1. FIFO unchanged.
- RespDepth = 4, 4 loads issued with no responses → 5th load on port 0 gets `req_ready_o[0] = 0`; a concurrent store on port 1 is still granted.
- FIFO full, a response pops in the same cycle a load is presented → load not granted that cycle, granted the next cycle.
- Head = port 3, `resp_ready_i[3] = 0`, `out_valid_i = 1` → `out_ready_o = 0`; the response stalls while another port's ready has no effect.
- Reset asserted with 2 outstanding entries → FIFO empty, `rr_q = 0`, all outputs 0 asynchronously.
